matrix_result_reader: RTL and testbench
=======================================

Name: matrix_result_reader

Overview:
Drains the result matrix from the output block_ram after matmul asserts valid, and streams it out as a valid/ready beat stream.
- Sits on the read side of the result RAM: matmul owns wr_addr/wr_data/wr_ena; this block owns rd_addr and consumes rd_data.
- Read order is row-major, addresses 0..A*C-1, one beat per element, with full backpressure support.

Parameters:
- A, 16: result rows.
- C, 24: result columns.
- OUT_BITS, 32: element width; matches the RAM width.
- M3_L, A*C: derived element count. Must not be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin drain; sampled at the clk rising edge; typically driven by matmul valid.
- m3_rd_addr  out  $clog2(M3_L)  result RAM read address.
- m3_rd_data  in  OUT_BITS  result RAM read data; valid one cycle after the address is presented (synchronous read).
- out_data  out  OUT_BITS  element value.
- out_row  out  $clog2(A)  row index of out_data.
- out_col  out  $clog2(C)  column index of out_data.
- out_last  out  1  high on the beat with index M3_L-1.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- busy  out  1  drain in progress.
- done  out  1  full matrix delivered.
- checksum  out  OUT_BITS  see Optional Feature.

Behaviour:
- Reset values: m3_rd_addr=0, out_valid=0, out_last=0, out_data/out_row/out_col=0, busy=0, done=0, checksum=0. Reset flushes the buffer and any in-flight read, and forces state IDLE.
- States:
  - IDLE: start=1 -> READ; busy=1, done=0, issue counter=0.
  - READ: issue read addresses. After the address M3_L-1 has been issued -> DRAIN.
  - DRAIN: wait until the buffer is empty and no read is in flight -> DONE.
  - DONE: done=1, busy=0. start=1 -> READ (restart from address 0; done falls the same edge).
- start while in READ or DRAIN is ignored.
- Read issue rule: issue on a cycle iff occ + inflight - pop < 2, where:
  - occ = 2-entry output buffer occupancy;
  - inflight = 1 if an address was issued last cycle;
  - pop = out_valid & out_ready.
  - This sustains 1 beat/clk with out_ready held high, and the buffer never overflows.
- Capture: m3_rd_data is written into the buffer the cycle after issue, tagged with row, col and last from a pipeline register.
- Row/col generation: counters only, no divider. col wraps C-1 -> 0 and increments row. row wraps A-1 -> 0 only on restart.
- Latency: start high at edge N -> first address driven after edge N; first out_valid after edge N+2.
- Output rule: out_data/out_row/out_col/out_last are stable while out_valid=1 and out_ready=0. The beat is transferred on an edge with both high.
- done rises on the edge after the out_last transfer.
- Simultaneous push and pop with occ=2 cannot happen (credit rule). Push and pop with occ=1 keeps occ=1.
- m3_rd_addr holds its last issued value when not issuing.

Optional Feature:
- Macro: MATRIX_RESULT_READER_CHECKSUM_EN.
- Defined:
  - checksum clears to 0 on the start edge.
  - It adds out_data (mod 2^OUT_BITS) on every accepted beat.
  - It is stable from the rise of done until the next start.
- Undefined: checksum is tied to 0 and no adder is synthesized.

Test Plan:
- Load the result RAM with value = address, hold out_ready=1, pulse start -> 384 beats on consecutive cycles:
  - data 0..383, row/col (0,0)..(15,23);
  - out_last only on beat 383;
  - done rises 1 clk after that beat.
- Same load, out_ready toggling 1,0,1,0 -> no beat lost or duplicated; data stable through every out_ready=0 cycle; the sequence is still 0..383.
- out_ready=0 for 10 cycles right after start -> at most 2 buffered beats; then out_ready=1 -> beats 0,1,2,... with no gap once flowing.
- rst asserted at beat 100 for 1 cycle, then start re-pulsed -> outputs at reset values the cycle after rst; the restarted stream begins at data 0, (0,0).
- start pulsed again mid-drain -> ignored, stream continues. start in DONE -> second full drain, identical to the first.
- With MATRIX_RESULT_READER_CHECKSUM_EN and RAM=address, full drain -> checksum = 73536 (0..383 summed). Without the macro -> checksum stays 0.

Source files
------------

// File: rtl/matrix_result_reader.sv
// Drains the A x C result RAM in row-major order into a valid/ready stream of tagged beats.
// Latency: start edge N -> address 0 after N, first out_valid after N+2; full rate with out_ready high; optional MATRIX_RESULT_READER_CHECKSUM_EN.
module matrix_result_reader #(
    parameter int A        = 16,
    parameter int C        = 24,
    parameter int OUT_BITS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [$clog2(A*C)-1:0]       m3_rd_addr,
    input  logic [OUT_BITS-1:0]          m3_rd_data,
    output logic [OUT_BITS-1:0]          out_data,
    output logic [$clog2(A)-1:0]         out_row,
    output logic [$clog2(C)-1:0]         out_col,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic [OUT_BITS-1:0]          checksum
);
    localparam int M3_L = A * C;
    localparam int AW   = $clog2(M3_L);
    localparam int RW   = $clog2(A);
    localparam int CW   = $clog2(C);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state_q;
    logic [AW-1:0]         cnt_q, addr_q;
    logic [RW-1:0]         row_q, tag_row_q;
    logic [CW-1:0]         col_q, tag_col_q;
    logic                  tag_last_q, inflight_q;
    logic                  busy_q, done_q;
    logic [1:0]            occ_q;
    logic [OUT_BITS-1:0]   h_data_q, s_data_q;
    logic [RW-1:0]         h_row_q, s_row_q;
    logic [CW-1:0]         h_col_q, s_col_q;
    logic                  h_last_q, s_last_q;

    logic                  pop, push, issue, issue_last, start_acc;
    logic [2:0]            credit_use_d, credit_lim_d;

    assign pop          = out_valid & out_ready;
    assign push         = inflight_q;
    // occ + inflight - pop < 2, rearranged to stay unsigned
    assign credit_use_d = {1'b0, occ_q} + {2'b00, inflight_q};
    assign credit_lim_d = 3'd2 + {2'b00, pop};
    assign issue        = (state_q == READ) && (credit_use_d < credit_lim_d);
    assign issue_last   = (cnt_q == AW'(M3_L - 1));
    assign start_acc    = start && ((state_q == IDLE) || (state_q == DONE));

    assign m3_rd_addr = issue ? cnt_q : addr_q;
    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = h_data_q;
    assign out_row    = h_row_q;
    assign out_col    = h_col_q;
    assign out_last   = h_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            tag_row_q  <= '0;
            tag_col_q  <= '0;
            tag_last_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                addr_q     <= cnt_q;
                tag_row_q  <= row_q;
                tag_col_q  <= col_q;
                tag_last_q <= issue_last;
                cnt_q      <= cnt_q + 1'b1;
                if (col_q == CW'(C - 1)) begin
                    col_q <= '0;
                    if (!issue_last) row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q <= READ;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                    row_q   <= '0;
                    col_q   <= '0;
                end
                READ: if (issue && issue_last) state_q <= DRAIN;
                DRAIN: if (occ_q == 2'd0 && !inflight_q) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-entry skid buffer; head entry drives the outputs directly
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= 2'd0;
            h_data_q <= '0;
            h_row_q  <= '0;
            h_col_q  <= '0;
            h_last_q <= 1'b0;
            s_data_q <= '0;
            s_row_q  <= '0;
            s_col_q  <= '0;
            s_last_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        h_data_q <= m3_rd_data;
                        h_row_q  <= tag_row_q;
                        h_col_q  <= tag_col_q;
                        h_last_q <= tag_last_q;
                    end else begin
                        s_data_q <= m3_rd_data;
                        s_row_q  <= tag_row_q;
                        s_col_q  <= tag_col_q;
                        s_last_q <= tag_last_q;
                    end
                    occ_q <= occ_q + 1'b1;
                end
                2'b01: begin
                    h_data_q <= s_data_q;
                    h_row_q  <= s_row_q;
                    h_col_q  <= s_col_q;
                    h_last_q <= s_last_q;
                    occ_q    <= occ_q - 1'b1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        h_data_q <= m3_rd_data;
                        h_row_q  <= tag_row_q;
                        h_col_q  <= tag_col_q;
                        h_last_q <= tag_last_q;
                    end else begin
                        h_data_q <= s_data_q;
                        h_row_q  <= s_row_q;
                        h_col_q  <= s_col_q;
                        h_last_q <= s_last_q;
                        s_data_q <= m3_rd_data;
                        s_row_q  <= tag_row_q;
                        s_col_q  <= tag_col_q;
                        s_last_q <= tag_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MATRIX_RESULT_READER_CHECKSUM_EN
    logic [OUT_BITS-1:0] checksum_q;
    always_ff @(posedge clk) begin
        if (rst)            checksum_q <= '0;
        else if (start_acc) checksum_q <= '0;
        else if (pop)       checksum_q <= checksum_q + h_data_q;
    end
    assign checksum = checksum_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign checksum         = '0;
`endif

endmodule

// File: tb/tb_matrix_result_reader.sv
// Bench for matrix_result_reader: RAM model plus a stream reference built from row-major indexing.
module tb_matrix_result_reader;
    localparam int A  = 16;
    localparam int C  = 24;
    localparam int W  = 32;
    localparam int L  = A * C;
    localparam int AW = $clog2(L);
    localparam int RW = $clog2(A);
    localparam int CW = $clog2(C);

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic [AW-1:0] m3_rd_addr;
    logic [W-1:0]  m3_rd_data;
    logic [W-1:0]  out_data, checksum;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_last, out_valid, busy, done;

    logic [W-1:0]  mem [L];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) m3_rd_data <= mem[m3_rd_addr];

    matrix_result_reader #(.A(A), .C(C), .OUT_BITS(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .m3_rd_addr(m3_rd_addr), .m3_rd_data(m3_rd_data),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_checksum();
        logic [W-1:0] s = '0;
`ifdef MATRIX_RESULT_READER_CHECKSUM_EN
        for (int i = 0; i < L; i++) s = s + mem[i];
`endif
        return s;
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_last"},  32'(out_last), 0);
        check({tag, "_data"},  out_data, 0);
        check({tag, "_row"},   32'(out_row), 0);
        check({tag, "_col"},   32'(out_col), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_addr"},  32'(m3_rd_addr), 0);
        check({tag, "_csum"},  checksum, 0);
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 ready low 10 cycles, 3 random ready
    task automatic drain(input int mode, input int start_at, input int abort_at, input string tag);
        int idx = 0, cyc = 0, first = -1, lastc = -1;
        logic stall = 1'b0;
        logic r;
        logic [W-1:0]  sd;
        logic [RW-1:0] sr;
        logic [CW-1:0] sc;
        logic          sl;
        @(negedge clk);
        start     = 1'b1;
        out_ready = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on_start"}, 32'(busy), 1);
        check({tag, "_done_on_start"}, 32'(done), 0);
        check({tag, "_addr0"}, 32'(m3_rd_addr), 0);
        check({tag, "_valid_early"}, 32'(out_valid), 0);
        while (idx < L && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2) == 1;
                2:       r = (cyc > 10);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            start     = (idx == start_at);
            if (mode == 2 && cyc == 10) begin
                check({tag, "_hold_addr"}, 32'(m3_rd_addr), 1);
                check({tag, "_hold_valid"}, 32'(out_valid), 1);
            end
            if (stall) begin
                check({tag, "_stable_data"}, out_data, sd);
                check({tag, "_stable_rc"}, {out_last, 18'd0, out_row, out_col}, {sl, 18'd0, sr, sc});
            end
            if (idx == abort_at) begin
                rst       = 1'b1;
                out_ready = 1'b0;
                break;
            end
            if (out_valid && r) begin
                check({tag, "_data"}, out_data, mem[idx]);
                check({tag, "_row"},  32'(out_row), 32'(idx / C));
                check({tag, "_col"},  32'(out_col), 32'(idx % C));
                check({tag, "_last"}, 32'(out_last), 32'(idx == L - 1));
                if (first < 0) first = cyc;
                lastc = cyc;
                idx++;
            end
            stall = out_valid && !r;
            sd = out_data; sr = out_row; sc = out_col; sl = out_last;
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            @(negedge clk);
            rst = 1'b0;
            reset_checks({tag, "_rst"});
        end else begin
            check({tag, "_beats"}, 32'(idx), 32'(L));
            @(negedge clk);
            check({tag, "_done_not_yet"}, 32'(done), 0);
            @(negedge clk);
            check({tag, "_done"}, 32'(done), 1);
            check({tag, "_busy_off"}, 32'(busy), 0);
            check({tag, "_valid_off"}, 32'(out_valid), 0);
            check({tag, "_csum"}, checksum, exp_checksum());
            if (mode == 0) begin
                check({tag, "_first_latency"}, 32'(first), 2);
                check({tag, "_no_gap"}, 32'(lastc - first), 32'(L - 1));
            end
            if (mode == 2) begin
                check({tag, "_first_after_hold"}, 32'(first), 11);
                check({tag, "_no_gap"}, 32'(lastc - first), 32'(L - 1));
            end
            repeat (3) @(negedge clk);
            check({tag, "_csum_hold"}, checksum, exp_checksum());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < L; i++) mem[i] = W'(i);
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;

        drain(0, -1, -1, "full");
`ifdef MATRIX_RESULT_READER_CHECKSUM_EN
        check("csum_addr_sum", checksum, 73536);
`endif
        drain(1, -1, -1, "toggle");
        drain(2, -1, -1, "hold");
        drain(0, -1, -1, "again");

        for (int i = 0; i < L; i++) mem[i] = $urandom;
        drain(3, 150, -1, "rand_midstart");
        drain(0, -1, 100, "abort");
        drain(0, -1, -1, "after_rst");
        drain(3, -1, -1, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
